// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
//  Module   : mdu
//  Purpose  : EX-stage multiply/divide unit owning HI/LO. mult/multu/div/divu
//             run with a fixed busy latency; mthi/mtlo write in one cycle.
//             Define MDU_MADD_EN to add madd/maddu/msub/msubu.
//  Revision : 1.0  initial release
// ============================================================================
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    input  logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MTHI  = 4'd5;
    localparam logic [3:0] c_OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] c_OP_MADD  = 4'd7;
    localparam logic [3:0] c_OP_MADDU = 4'd8;
    localparam logic [3:0] c_OP_MSUB  = 4'd9;
    localparam logic [3:0] c_OP_MSUBU = 4'd10;
`endif

    localparam logic [3:0] c_MULT_LAT = 4'(MULT_CYCLES);
    localparam logic [3:0] c_DIV_LAT  = 4'(DIV_CYCLES);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_we_q, pend_we_d;

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_is_div;
    logic        w_by_zero;
    logic [31:0] w_a_mag, w_b_mag;
    logic [31:0] w_dvd, w_dvs;
    logic [31:0] w_q_raw, w_r_raw;
    logic [31:0] w_quot, w_rem;

    // Low 64 bits of a 64x64 product of sign-extended operands is the signed product.
    assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // One unsigned divider serves both div and divu; signed div works on
    // magnitudes and fixes signs afterwards, so 0x80000000 / -1 wraps cleanly.
    assign w_is_div  = (op == c_OP_DIV);
    assign w_by_zero = (b == 32'd0);
    assign w_a_mag   = a[31] ? (32'd0 - a) : a;
    assign w_b_mag   = b[31] ? (32'd0 - b) : b;
    assign w_dvd     = w_is_div ? w_a_mag : a;
    assign w_dvs     = w_by_zero ? 32'd1 : (w_is_div ? w_b_mag : b);
    assign w_q_raw   = w_dvd / w_dvs;
    assign w_r_raw   = w_dvd % w_dvs;
    assign w_quot    = (w_is_div && (a[31] ^ b[31])) ? (32'd0 - w_q_raw) : w_q_raw;
    assign w_rem     = (w_is_div && a[31]) ? (32'd0 - w_r_raw) : w_r_raw;

`ifdef MDU_MADD_EN
    logic [63:0] w_acc;
    assign w_acc = {hi_q, lo_q};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        c_OP_MULT: begin
                            {pend_hi_d, pend_lo_d} = w_prod_s;
                            pend_we_d = 1'b1;
                            cnt_d     = c_MULT_LAT;
                            state_d   = S_RUN;
                        end
                        c_OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = w_prod_u;
                            pend_we_d = 1'b1;
                            cnt_d     = c_MULT_LAT;
                            state_d   = S_RUN;
                        end
                        c_OP_DIV, c_OP_DIVU: begin
                            pend_hi_d = w_rem;
                            pend_lo_d = w_quot;
                            pend_we_d = ~w_by_zero;
                            cnt_d     = c_DIV_LAT;
                            state_d   = S_RUN;
                        end
                        c_OP_MTHI: hi_d = a;
                        c_OP_MTLO: lo_d = a;
`ifdef MDU_MADD_EN
                        c_OP_MADD, c_OP_MADDU, c_OP_MSUB, c_OP_MSUBU: begin
                            case (op)
                                c_OP_MADD:  {pend_hi_d, pend_lo_d} = w_acc + w_prod_s;
                                c_OP_MADDU: {pend_hi_d, pend_lo_d} = w_acc + w_prod_u;
                                c_OP_MSUB:  {pend_hi_d, pend_lo_d} = w_acc - w_prod_s;
                                default:    {pend_hi_d, pend_lo_d} = w_acc - w_prod_u;
                            endcase
                            pend_we_d = 1'b1;
                            cnt_d     = c_MULT_LAT;
                            state_d   = S_RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                    if (pend_we_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdu
//  Purpose  : Self-checking bench for mdu: directed vector table plus
//             hand-written busy-window and reset-abort sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mdu;

    logic        clk;
    logic        reset;
    logic [31:0] a, b;
    logic [3:0]  op;
    logic        start;
    logic        busy;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .op    (op),
        .start (start),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        int          cyc;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
    endtask

    // Counts busy cycles from the negedge after the start edge, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic preset(input logic [31:0] h, input logic [31:0] l);
        issue(4'd5, h, 32'd0);
        issue(4'd6, l, 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b0; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;

        //           name         op     a             b             pre_hi        pre_lo        cyc exp_hi        exp_lo
        vecs.push_back('{"mult",      4'd1, 32'hFFFFFFFF, 32'h00000002, 32'h0,        32'h0,        5,  32'hFFFFFFFF, 32'hFFFFFFFE});
        vecs.push_back('{"multu",     4'd2, 32'hFFFFFFFF, 32'h00000002, 32'h0,        32'h0,        5,  32'h00000001, 32'hFFFFFFFE});
        vecs.push_back('{"mult_min",  4'd1, 32'h80000000, 32'h80000000, 32'h0,        32'h0,        5,  32'h40000000, 32'h00000000});
        vecs.push_back('{"multu_max", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        5,  32'hFFFFFFFE, 32'h00000001});
        vecs.push_back('{"div_n7_2",  4'd3, 32'hFFFFFFF9, 32'h00000002, 32'h0,        32'h0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD});
        vecs.push_back('{"div_7_n2",  4'd3, 32'h00000007, 32'hFFFFFFFE, 32'h0,        32'h0,        10, 32'h00000001, 32'hFFFFFFFD});
        vecs.push_back('{"div_n7_n2", 4'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0,        32'h0,        10, 32'hFFFFFFFF, 32'h00000003});
        vecs.push_back('{"divu_7_2",  4'd4, 32'h00000007, 32'h00000002, 32'h0,        32'h0,        10, 32'h00000001, 32'h00000003});
        vecs.push_back('{"divu_big",  4'd4, 32'hFFFFFFF9, 32'h00000002, 32'h0,        32'h0,        10, 32'h00000001, 32'h7FFFFFFC});
        vecs.push_back('{"divu_by0",  4'd4, 32'h00001234, 32'h00000000, 32'hAAAA0000, 32'h0000BBBB, 10, 32'hAAAA0000, 32'h0000BBBB});
        vecs.push_back('{"div_by0",   4'd3, 32'hFFFF0000, 32'h00000000, 32'h11112222, 32'h33334444, 10, 32'h11112222, 32'h33334444});
        vecs.push_back('{"div_ovf",   4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h6,                10, 32'h00000000, 32'h80000000});
        vecs.push_back('{"op_none",   4'd0, 32'hDEADBEEF, 32'h00000003, 32'h00000042, 32'h00000043, 0,  32'h00000042, 32'h00000043});
        vecs.push_back('{"op_bad",    4'd15, 32'hDEADBEEF, 32'h00000003, 32'h00000044, 32'h00000045, 0, 32'h00000044, 32'h00000045});
`ifdef MDU_MADD_EN
        vecs.push_back('{"madd",      4'd7, 32'h00000003, 32'h00000004, 32'h0,        32'h0000000A, 5,  32'h00000000, 32'h00000016});
        vecs.push_back('{"msubu",     4'd10, 32'hFFFFFFFF, 32'h00000001, 32'h0,       32'h00000016, 5,  32'hFFFFFFFF, 32'h00000017});
        vecs.push_back('{"maddu_cy",  4'd8, 32'h00000001, 32'h00000001, 32'h0,        32'hFFFFFFFF, 5,  32'h00000001, 32'h00000000});
        vecs.push_back('{"msub",      4'd9, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h00000000, 5,  32'h00000000, 32'h00000001});
`else
        vecs.push_back('{"madd_off",  4'd7, 32'h00000003, 32'h00000004, 32'h0,        32'h0000000A, 0,  32'h00000000, 32'h0000000A});
        vecs.push_back('{"msubu_off", 4'd10, 32'hFFFFFFFF, 32'h00000001, 32'h7,       32'h00000016, 0,  32'h00000007, 32'h00000016});
`endif

        repeat (3) @(negedge clk);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        reset = 1'b1;

        issue(4'd5, 32'h12345678, 32'h0);
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_lo", lo, 32'h0);
        chk("mthi_busy", {31'd0, busy}, 32'h0);
        issue(4'd6, 32'h9ABCDEF0, 32'h0);
        chk("mtlo_lo", lo, 32'h9ABCDEF0);
        chk("mtlo_hi", hi, 32'h12345678);
        chk("mtlo_busy", {31'd0, busy}, 32'h0);

        foreach (vecs[i]) begin
            preset(vecs[i].pre_hi, vecs[i].pre_lo);
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_idle(n);
            chk({vecs[i].name, "_cyc"}, 32'(n), 32'(vecs[i].cyc));
            chk({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
            chk({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
        end

        // Start issued in the second busy cycle must be ignored.
        preset(32'h00001111, 32'h00002222);
        issue(4'd1, 32'd3, 32'd4);
        @(negedge clk);
        op = 4'd1; a = 32'd5; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        wait_idle(n);
        chk("ign_cyc", 32'(n + 2), 32'd5);
        chk("ign_hi", hi, 32'h0);
        chk("ign_lo", lo, 32'd12);
        repeat (3) @(negedge clk);
        chk("ign_busy_after", {31'd0, busy}, 32'h0);
        chk("ign_lo_after", lo, 32'd12);

        // Reset in the third busy cycle aborts with no later commit.
        preset(32'h00000055, 32'h00000066);
        issue(4'd1, 32'd3, 32'd4);
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_pre", {31'd0, busy}, 32'h1);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'h0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_late_busy", {31'd0, busy}, 32'h0);
        chk("abort_late_hi", hi, 32'h0);
        chk("abort_late_lo", lo, 32'h0);

        // Reset overrides a start sampled on the same edge.
        preset(32'h00000077, 32'h00000088);
        @(negedge clk);
        reset = 1'b0; op = 4'd5; a = 32'hCAFEF00D; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 4'd0; reset = 1'b1;
        chk("rst_start_hi", hi, 32'h0);
        chk("rst_start_busy", {31'd0, busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit sitting beside the ALU in the EX stage.
- Takes the same rs/rt operands the ALU receives and owns the architectural HI/LO registers.
- Runs mult/multu/div/divu over a fixed multi-cycle latency with a busy flag, so the hazard unit can stall mfhi/mflo and later MDU ops.
- mthi/mtlo write HI/LO in a single cycle.

Parameters:
- MULT_CYCLES, default 5: busy cycles for mult/multu (and madd family); legal range 1..15.
- DIV_CYCLES, default 10: busy cycles for div/divu; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on the rising edge of clk).
- a  input  32  operand rs.
- b  input  32  operand rt.
- op  input  4  MDU operation.
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo.
  - 7 madd, 8 maddu, 9 msub, 10 msubu (optional feature only).
  - All other codes behave as none.
- start  input  1  qualifies op for one cycle.
- busy  output  1  high while a multi-cycle op is in flight.
- hi  output  32  committed HI.
- lo  output  32  committed LO.

Behaviour:
- Reset (reset==0 at a clk edge):
  - hi=0, lo=0, busy=0, counter=0, pending result cleared.
  - Overrides any start sampled on the same edge.
  - Aborts an in-flight op with no commit.
- States: IDLE (busy=0) and RUN (busy=1). A 4-bit down-counter tracks the remaining cycles.
- IDLE, start=1, op in {mult, multu, div, divu, enabled madd family}:
  - At that edge, compute the 64-bit result from the a/b sampled on this edge and hold it in pending_hi/pending_lo.
  - Load counter = MULT_CYCLES or DIV_CYCLES, go to RUN, busy=1 from the next cycle.
- RUN, each edge: counter decrements.
  - On the edge where counter==1: hi/lo <= pending, busy=0, return to IDLE.
  - busy is therefore high for exactly N cycles, and the new hi/lo are visible in the first cycle busy is 0.
- IDLE, start=1, op=mthi: hi<=a at that edge; lo unchanged; busy stays 0.
- IDLE, start=1, op=mtlo: lo<=a at that edge; hi unchanged; busy stays 0.
- Any start while busy=1: ignored (no state change, no restart). The upstream stall is responsible for not issuing it.
- start=0, or op none/unknown: no effect.
- Arithmetic:
  - mult: signed 32x32 to 64; HI=[63:32], LO=[31:0].
  - multu: unsigned 32x32 to 64; HI=[63:32], LO=[31:0].
  - div: LO=signed quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned quotient in LO and remainder in HI.
  - Divide by zero (b==0, div or divu): the op still runs DIV_CYCLES with busy=1, but the commit leaves hi/lo unchanged.
  - div of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0 (wrap, no trap).
- hi/lo are registered outputs and only change at the edges defined above.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - op 7/8: {hi,lo} + the signed/unsigned product.
  - op 9/10: {hi,lo} - the signed/unsigned product.
  - All four use 64-bit modulo arithmetic and MULT_CYCLES latency.
  - The accumulation base is the hi/lo value committed at the start edge.
- Undefined: codes 7-10 behave as none; no extra adder logic is present.

Test Plan:
- Reset then mthi 0x12345678, then mtlo 0x9ABCDEF0 -> hi=0x12345678 one cycle after the first, lo=0x9ABCDEF0 one cycle after the second; busy stays 0.
- mult a=0xFFFFFFFF, b=2 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. Same operands with multu -> hi=0x00000001, lo=0xFFFFFFFE.
- div a=0xFFFFFFF9 (-7), b=2 -> busy high exactly 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu with a=7, b=2 -> lo=3, hi=1.
- divu by b=0 with hi=0xAAAA0000, lo=0x0000BBBB preset -> busy for 10 cycles, then hi/lo unchanged. Separately, div 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
- mult 3*4 started, then start=1 mult 5*5 in the 2nd busy cycle -> second op ignored, lo=12 after 5 cycles.
- Repeat the 3*4 mult and pull reset low in the 3rd busy cycle -> hi=lo=0, busy=0 next cycle, and no later commit.
- (MDU_MADD_EN) hi=0, lo=10, madd 3*4 -> lo=22. Then msubu 0xFFFFFFFF*1 -> {hi,lo}=0xFFFFFFFF_00000017.
